itcm_arb: RTL and testbench

ITCM_ARB -- requirements
Module: itcm_arb

---
 rtl/itcm_arb.sv | 148 ++++++++++++++
 tb/tb_itcm_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_arb.sv
// ITCM arbiter: shares one combinational-read ITCM port between the IFU fetch
// channel and the LSU data-read channel, with one response slot, LSU priority
// and a bounded IFU starvation window.
module itcm_arb #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned ITCM_BYTES = 4096,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          ifu_req_vld,
    output logic          ifu_req_rdy,
    input  logic [AW-1:0] ifu_req_addr,
    output logic          ifu_rsp_vld,
    input  logic          ifu_rsp_rdy,
    output logic [DW-1:0] ifu_rsp_rdata,
    output logic          ifu_rsp_err,
    input  logic          ifu_flush,

    input  logic          lsu_req_vld,
    output logic          lsu_req_rdy,
    input  logic [AW-1:0] lsu_req_addr,
    output logic          lsu_rsp_vld,
    input  logic          lsu_rsp_rdy,
    output logic [DW-1:0] lsu_rsp_rdata,
    output logic          lsu_rsp_err,

    output logic [AW-1:0] itcm_addr,
    input  logic [DW-1:0] itcm_rdata,

    output logic          busy
);

    // Starvation counter is 4 bits wide, enough for the 1..15 window.
    localparam int unsigned   CW       = 4;
    localparam logic [AW-1:0] LP_LIMIT = AW'(ITCM_BYTES);
    localparam logic [CW-1:0] LP_SMAX  = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RSP_IFU = 2'd1,
        ST_RSP_LSU = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic [CW-1:0] r_starve;

    logic          w_ifu_accept;
    logic          w_lsu_accept;
    logic          w_flush_drop;
    logic          w_slot_free;
    logic          w_ifu_cand;
    logic          w_ifu_win;
    logic          w_lsu_win;
    logic          w_ifu_addr_err;
    logic          w_lsu_addr_err;
    logic          w_grant_err;
    logic [AW-1:0] w_grant_addr;

    // Slot release, arbitration and address decode for the current cycle.
    always_comb begin
        w_ifu_accept   = 1'b0;
        w_lsu_accept   = 1'b0;
        w_flush_drop   = 1'b0;
        w_slot_free    = 1'b0;
        w_ifu_cand     = 1'b0;
        w_ifu_win      = 1'b0;
        w_lsu_win      = 1'b0;
        w_ifu_addr_err = 1'b0;
        w_lsu_addr_err = 1'b0;
        w_grant_err    = 1'b0;
        w_grant_addr   = '0;

        w_ifu_accept = (r_state == ST_RSP_IFU) & ifu_rsp_rdy;
        w_lsu_accept = (r_state == ST_RSP_LSU) & lsu_rsp_rdy;
        w_flush_drop = (r_state == ST_RSP_IFU) & ifu_flush;

        // Nothing is granted while reset is held.
        w_slot_free = rst_n & ((r_state == ST_IDLE) | w_ifu_accept |
                               w_lsu_accept | w_flush_drop);

        // A flushing IFU never handshakes; its slot falls through to the LSU.
        w_ifu_cand = ifu_req_vld & ~ifu_flush;
        w_ifu_win  = w_slot_free & w_ifu_cand &
                     ((r_starve == LP_SMAX) | ~lsu_req_vld);
        w_lsu_win  = w_slot_free & lsu_req_vld & ~w_ifu_win;

        // IFU fetches are halfword aligned, LSU reads are word aligned.
        w_ifu_addr_err = (ifu_req_addr >= LP_LIMIT) | ifu_req_addr[0];
        w_lsu_addr_err = (lsu_req_addr >= LP_LIMIT) |
                         (lsu_req_addr[1:0] != 2'b00);

        if (w_ifu_win) begin
            w_grant_addr = ifu_req_addr;
            w_grant_err  = w_ifu_addr_err;
        end else if (w_lsu_win) begin
            w_grant_addr = lsu_req_addr;
            w_grant_err  = w_lsu_addr_err;
        end
    end

    // State, response register and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_starve <= '0;
        end else begin
            if (w_ifu_win) begin
                r_state <= ST_RSP_IFU;
                r_rdata <= w_grant_err ? '0 : itcm_rdata;
                r_err   <= w_grant_err;
            end else if (w_lsu_win) begin
                r_state <= ST_RSP_LSU;
                r_rdata <= w_grant_err ? '0 : itcm_rdata;
                r_err   <= w_grant_err;
            end else if (w_slot_free) begin
                r_state <= ST_IDLE;
            end

            if (w_ifu_win || !ifu_req_vld) begin
                r_starve <= '0;
            end else if (w_lsu_win && (r_starve != LP_SMAX)) begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end

    // Output mapping; the response side comes straight from registers.
    always_comb begin
        ifu_req_rdy   = w_ifu_win;
        lsu_req_rdy   = w_lsu_win;
        itcm_addr     = w_grant_addr;
        ifu_rsp_vld   = (r_state == ST_RSP_IFU);
        lsu_rsp_vld   = (r_state == ST_RSP_LSU);
        ifu_rsp_rdata = r_rdata;
        lsu_rsp_rdata = r_rdata;
        ifu_rsp_err   = r_err;
        lsu_rsp_err   = r_err;
        busy          = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_itcm_arb.sv
// Self-checking bench for itcm_arb: reset, directed corner sequences, a
// vector table of single reads, then randomized traffic against a queue model.
module tb_itcm_arb;

    localparam int unsigned AW         = 32;
    localparam int unsigned DW         = 32;
    localparam int unsigned ITCM_BYTES = 4096;
    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned NVEC       = 11;
    localparam int unsigned NRAND      = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req_vld, ifu_req_rdy, ifu_rsp_vld, ifu_rsp_rdy, ifu_rsp_err, ifu_flush;
    logic [AW-1:0] ifu_req_addr;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_req_vld, lsu_req_rdy, lsu_rsp_vld, lsu_rsp_rdy, lsu_rsp_err;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_rsp_rdata;
    logic [AW-1:0] itcm_addr;
    logic [DW-1:0] itcm_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    itcm_arb #(.AW(AW), .DW(DW), .ITCM_BYTES(ITCM_BYTES), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_vld(ifu_req_vld), .ifu_req_rdy(ifu_req_rdy), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_rdy(ifu_rsp_rdy), .ifu_rsp_rdata(ifu_rsp_rdata),
        .ifu_rsp_err(ifu_rsp_err), .ifu_flush(ifu_flush),
        .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy), .lsu_req_addr(lsu_req_addr),
        .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy), .lsu_rsp_rdata(lsu_rsp_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .itcm_addr(itcm_addr), .itcm_rdata(itcm_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign itcm_rdata = memf(itcm_addr);

    function automatic bit ifu_bad(input logic [31:0] a);
        return (a >= ITCM_BYTES) || (a % 2 != 0);
    endfunction

    function automatic bit lsu_bad(input logic [31:0] a);
        return (a >= ITCM_BYTES) || (a % 4 != 0);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifu_req_vld  = 1'b0;
        ifu_req_addr = '0;
        ifu_rsp_rdy  = 1'b1;
        ifu_flush    = 1'b0;
        lsu_req_vld  = 1'b0;
        lsu_req_addr = '0;
        lsu_rsp_rdy  = 1'b1;
    endtask

    // Vector table of single reads issued from an idle arbiter.
    typedef struct {
        bit          is_lsu;
        logic [31:0] addr;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic set_vec(input int i, input bit is_lsu, input logic [31:0] a, input bit err);
        vecs[i].is_lsu    = is_lsu;
        vecs[i].addr      = a;
        vecs[i].exp_err   = err;
        vecs[i].exp_rdata = err ? 32'h0 : memf(a);
    endtask

    // Reference model state: pending responses and consecutive LSU wins.
    typedef struct {
        bit          is_ifu;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rsp_t        pend[$];
    rsp_t        m_new;
    int          m_starve;
    bit          m_have, m_own_ifu, m_consumed, m_free, e_ifu, e_lsu;
    logic [31:0] e_addr;
    logic [7:0]  pat_ifu;

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'(ITCM_BYTES + $urandom_range(0, 64));
        if (r == 1) return 32'($urandom());
        return 32'($urandom_range(0, ITCM_BYTES - 1));
    endfunction

    initial begin
        // IFU wins only on the fourth and eighth grant.
        pat_ifu = 8'b1000_1000;
        set_vec(0,  1'b0, 32'h0000_0010, 1'b0);
        set_vec(1,  1'b0, 32'h0000_0012, 1'b0);
        set_vec(2,  1'b0, 32'h0000_0011, 1'b1);
        set_vec(3,  1'b0, 32'h0000_1000, 1'b1);
        set_vec(4,  1'b0, 32'h0000_0FFE, 1'b0);
        set_vec(5,  1'b1, 32'h0000_0000, 1'b0);
        set_vec(6,  1'b1, 32'h0000_0002, 1'b1);
        set_vec(7,  1'b1, 32'h0000_1000, 1'b1);
        set_vec(8,  1'b1, 32'h0000_0FFC, 1'b0);
        set_vec(9,  1'b1, 32'h0000_1001, 1'b1);
        set_vec(10, 1'b1, 32'hFFFF_FFFC, 1'b1);

        // Reset with both requesters active: nothing may be granted.
        idle_inputs();
        rst_n        = 1'b0;
        ifu_req_vld  = 1'b1;
        ifu_req_addr = 32'h20;
        lsu_req_vld  = 1'b1;
        lsu_req_addr = 32'h40;
        step();
        samp();
        chk1("rst_ifu_req_rdy", ifu_req_rdy, 1'b0);
        chk1("rst_lsu_req_rdy", lsu_req_rdy, 1'b0);
        chk32("rst_itcm_addr", itcm_addr, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ifu_rsp_vld", ifu_rsp_vld, 1'b0);
        chk1("rst_lsu_rsp_vld", lsu_rsp_vld, 1'b0);
        chk32("rst_ifu_rdata", ifu_rsp_rdata, 32'h0);
        chk32("rst_lsu_rdata", lsu_rsp_rdata, 32'h0);
        chk1("rst_ifu_err", ifu_rsp_err, 1'b0);
        chk1("rst_lsu_err", lsu_rsp_err, 1'b0);

        // Starvation window: both requesting continuously.
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            samp();
            chk1("starve_ifu_rdy", ifu_req_rdy, pat_ifu[k]);
            chk1("starve_lsu_rdy", lsu_req_rdy, ~pat_ifu[k]);
            step();
        end
        idle_inputs();
        step();
        step();

        // Vector table.
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_lsu) begin
                lsu_req_vld  = 1'b1;
                lsu_req_addr = vecs[i].addr;
            end else begin
                ifu_req_vld  = 1'b1;
                ifu_req_addr = vecs[i].addr;
            end
            samp();
            chk1("vec_ifu_req_rdy", ifu_req_rdy, ~vecs[i].is_lsu);
            chk1("vec_lsu_req_rdy", lsu_req_rdy, vecs[i].is_lsu);
            chk32("vec_itcm_addr", itcm_addr, vecs[i].addr);
            step();
            idle_inputs();
            samp();
            chk1("vec_ifu_rsp_vld", ifu_rsp_vld, ~vecs[i].is_lsu);
            chk1("vec_lsu_rsp_vld", lsu_rsp_vld, vecs[i].is_lsu);
            chk1("vec_busy", busy, 1'b1);
            chk32("vec_itcm_addr_idle", itcm_addr, 32'h0);
            if (vecs[i].is_lsu) begin
                chk32("vec_lsu_rdata", lsu_rsp_rdata, vecs[i].exp_rdata);
                chk1("vec_lsu_err", lsu_rsp_err, vecs[i].exp_err);
            end else begin
                chk32("vec_ifu_rdata", ifu_rsp_rdata, vecs[i].exp_rdata);
                chk1("vec_ifu_err", ifu_rsp_err, vecs[i].exp_err);
            end
            step();
            samp();
            chk1("vec_busy_after", busy, 1'b0);
            step();
        end

        // IFU response held for three cycles, then back-to-back LSU grant.
        ifu_req_vld  = 1'b1;
        ifu_req_addr = 32'h24;
        ifu_rsp_rdy  = 1'b0;
        samp();
        chk1("hold_ifu_grant", ifu_req_rdy, 1'b1);
        step();
        ifu_req_addr = 32'h28;
        lsu_req_vld  = 1'b1;
        lsu_req_addr = 32'h30;
        for (int k = 0; k < 3; k++) begin
            samp();
            chk1("hold_ifu_rsp_vld", ifu_rsp_vld, 1'b1);
            chk32("hold_ifu_rdata", ifu_rsp_rdata, memf(32'h24));
            chk1("hold_ifu_err", ifu_rsp_err, 1'b0);
            chk1("hold_ifu_req_rdy", ifu_req_rdy, 1'b0);
            chk1("hold_lsu_req_rdy", lsu_req_rdy, 1'b0);
            chk1("hold_busy", busy, 1'b1);
            step();
        end
        ifu_rsp_rdy = 1'b1;
        samp();
        chk1("b2b_lsu_grant", lsu_req_rdy, 1'b1);
        chk32("b2b_itcm_addr", itcm_addr, 32'h30);
        step();
        idle_inputs();
        samp();
        chk1("b2b_lsu_rsp_vld", lsu_rsp_vld, 1'b1);
        chk1("b2b_ifu_rsp_vld", ifu_rsp_vld, 1'b0);
        chk32("b2b_lsu_rdata", lsu_rsp_rdata, memf(32'h30));
        step();
        step();

        // Flush in RSP_IFU hands the slot to a waiting LSU in the same cycle.
        ifu_req_vld  = 1'b1;
        ifu_req_addr = 32'h44;
        ifu_rsp_rdy  = 1'b0;
        samp();
        chk1("flush_ifu_grant", ifu_req_rdy, 1'b1);
        step();
        ifu_flush    = 1'b1;
        lsu_req_vld  = 1'b1;
        lsu_req_addr = 32'h48;
        samp();
        chk1("flush_lsu_rdy", lsu_req_rdy, 1'b1);
        chk1("flush_ifu_rdy", ifu_req_rdy, 1'b0);
        chk32("flush_itcm_addr", itcm_addr, 32'h48);
        step();
        idle_inputs();
        samp();
        chk1("flush_ifu_rsp_vld", ifu_rsp_vld, 1'b0);
        chk1("flush_lsu_rsp_vld", lsu_rsp_vld, 1'b1);
        chk32("flush_lsu_rdata", lsu_rsp_rdata, memf(32'h48));
        step();
        step();

        // Reset in RSP_LSU discards the response and the starvation count.
        ifu_req_vld  = 1'b1;
        ifu_req_addr = 32'h50;
        lsu_req_vld  = 1'b1;
        lsu_req_addr = 32'h54;
        lsu_rsp_rdy  = 1'b0;
        samp();
        chk1("mrst_lsu_grant", lsu_req_rdy, 1'b1);
        step();
        samp();
        chk1("mrst_lsu_rsp_vld", lsu_rsp_vld, 1'b1);
        step();
        rst_n = 1'b0;
        samp();
        chk1("mrst_ifu_rdy", ifu_req_rdy, 1'b0);
        chk1("mrst_lsu_rdy", lsu_req_rdy, 1'b0);
        chk32("mrst_itcm_addr", itcm_addr, 32'h0);
        step();
        rst_n       = 1'b1;
        lsu_rsp_rdy = 1'b1;
        samp();
        chk1("mrst_lsu_rsp_vld_after", lsu_rsp_vld, 1'b0);
        chk1("mrst_busy_after", busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) samp();
            chk1("mrst_starve_ifu_rdy", ifu_req_rdy, pat_ifu[k]);
            chk1("mrst_starve_lsu_rdy", lsu_req_rdy, ~pat_ifu[k]);
            step();
        end

        // Randomized traffic against the reference model.
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        pend.delete();
        m_starve = 0;
        for (int c = 0; c < NRAND; c++) begin
            step();
            ifu_req_vld  = ($urandom_range(0, 99) < 60);
            lsu_req_vld  = ($urandom_range(0, 99) < 50);
            ifu_rsp_rdy  = ($urandom_range(0, 99) < 70);
            lsu_rsp_rdy  = ($urandom_range(0, 99) < 70);
            ifu_flush    = ($urandom_range(0, 99) < 10);
            ifu_req_addr = rand_addr();
            lsu_req_addr = rand_addr();
            samp();

            m_have     = (pend.size() != 0);
            m_own_ifu  = m_have && pend[0].is_ifu;
            m_consumed = m_have && (m_own_ifu ? (ifu_rsp_rdy || ifu_flush) : lsu_rsp_rdy);
            m_free     = !m_have || m_consumed;
            e_ifu      = m_free && ifu_req_vld && !ifu_flush &&
                         (m_starve == STARVE_MAX || !lsu_req_vld);
            e_lsu      = m_free && lsu_req_vld && !e_ifu;
            e_addr     = e_ifu ? ifu_req_addr : (e_lsu ? lsu_req_addr : 32'h0);

            chk1("rnd_ifu_req_rdy", ifu_req_rdy, e_ifu);
            chk1("rnd_lsu_req_rdy", lsu_req_rdy, e_lsu);
            chk32("rnd_itcm_addr", itcm_addr, e_addr);
            chk1("rnd_ifu_rsp_vld", ifu_rsp_vld, m_have && m_own_ifu);
            chk1("rnd_lsu_rsp_vld", lsu_rsp_vld, m_have && !m_own_ifu);
            chk1("rnd_busy", busy, m_have);
            chk1("rnd_rsp_mutex", ifu_rsp_vld && lsu_rsp_vld, 1'b0);
            if (m_have && m_own_ifu) begin
                chk32("rnd_ifu_rdata", ifu_rsp_rdata, pend[0].data);
                chk1("rnd_ifu_err", ifu_rsp_err, pend[0].err);
            end else if (m_have) begin
                chk32("rnd_lsu_rdata", lsu_rsp_rdata, pend[0].data);
                chk1("rnd_lsu_err", lsu_rsp_err, pend[0].err);
            end

            if (m_consumed) void'(pend.pop_front());
            if (e_ifu) begin
                m_new.is_ifu = 1'b1;
                m_new.err    = ifu_bad(ifu_req_addr);
                m_new.data   = m_new.err ? 32'h0 : memf(ifu_req_addr);
                pend.push_back(m_new);
            end else if (e_lsu) begin
                m_new.is_ifu = 1'b0;
                m_new.err    = lsu_bad(lsu_req_addr);
                m_new.data   = m_new.err ? 32'h0 : memf(lsu_req_addr);
                pend.push_back(m_new);
            end
            if (e_ifu || !ifu_req_vld) m_starve = 0;
            else if (e_lsu && m_starve < STARVE_MAX) m_starve++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
